usb_rx_bit_timer: RTL and testbench

Receive-side bit timing and byte recovery for the USB full-speed link. It samples the differential pair at 8 clocks per bit and resynchronises its sampling phase on every data edge. It NRZI-decodes, strips stuffed bits, assembles bytes LSB-first and flags end-of-packet. It sits between the D+/D- pads and the receive packet decoder, mirroring the transmit timer's 8-clock bit period and 64-byte packet limit.

---
 rtl/usb_pkg.sv | 26 ++
 rtl/usb_rx_edge_sync.sv | 42 ++++
 rtl/usb_rx_bit_timer.sv | 211 +++++++++++++++++++++
 tb/tb_usb_rx_bit_timer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg -- shared types and constants for the USB full-speed receive path.
//   rx_state_t : receive FSM states (IDLE, RCV, EOP, ERR)
//   LINE_*     : registered line-state encoding, {D+, D-}
//   SYNC_BYTE  : SYNC pattern as assembled LSB-first
//   STUFF_LIMIT: consecutive 1s after which a stuffed 0 follows
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RCV  = 2'd1,
    EOP  = 2'd2,
    ERR  = 2'd3
  } rx_state_t;

  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam int         STUFF_LIMIT = 6;

  function automatic logic is_jk(input logic [1:0] l);
    return (l == LINE_J) || (l == LINE_K);
  endfunction

endpackage

// File: rtl/usb_rx_edge_sync.sv
// usb_rx_edge_sync -- pad synchroniser and J/K edge detector.
//   clk, n_rst       : clock, async active-low reset
//   d_plus, d_minus  : raw asynchronous pad inputs
//   line             : registered line state (LINE_J / LINE_K / LINE_SE0)
//   jk_edge          : one-cycle pulse, aligned with line, on a J<->K change
// Pad to line/jk_edge latency is 3 clocks (2 sync flops + 1 line register).
module usb_rx_edge_sync
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  output logic [1:0] line,
  output logic       jk_edge
);

  logic [1:0] dp_ff, dm_ff;
  logic [1:0] line_next;

  // (1,1) is illegal on the bus and is folded into SE0
  always_comb begin
    line_next = {dp_ff[1], dm_ff[1]};
    if (dp_ff[1] && dm_ff[1]) line_next = LINE_SE0;
  end

  // Reset to J so leaving reset on an idle bus does not look like an edge
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_ff   <= 2'b11;
      dm_ff   <= 2'b00;
      line    <= LINE_J;
      jk_edge <= 1'b0;
    end else begin
      dp_ff   <= {dp_ff[0], d_plus};
      dm_ff   <= {dm_ff[0], d_minus};
      line    <= line_next;
      jk_edge <= is_jk(line_next) && is_jk(line) && (line_next != line);
    end
  end

endmodule

// File: rtl/usb_rx_bit_timer.sv
// usb_rx_bit_timer -- USB full-speed receive bit timing and byte recovery.
// Oversamples the line at CLKS_PER_BIT clocks per bit, re-centres the sample
// point on every J/K edge, NRZI-decodes, removes stuffed bits and assembles
// bytes LSB-first, then checks the SE0,SE0,J end-of-packet.
//   clk, n_rst        : clock, async active-low reset
//   d_plus, d_minus   : raw pads (asynchronous)
//   rx_en             : low forces IDLE and blocks new packets
//   rx_clr            : sync clear of rx_error/byte_count, back to IDLE
//   byte_out          : last assembled data byte (held)
//   byte_ready        : one-cycle strobe for byte_out
//   byte_count        : data bytes received in this packet
//   eop               : one-cycle strobe on a clean end-of-packet
//   rx_active         : packet in progress
//   rx_error          : sticky error flag
// Build option USB_RX_SYNC_CHECK_EN: when defined, the first 8 decoded bits
// must be the SYNC pattern and are not delivered; when undefined they are
// delivered and counted like any data byte.
module usb_rx_bit_timer
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       rx_en,
  input  logic       rx_clr,
  output logic [7:0] byte_out,
  output logic       byte_ready,
  output logic [6:0] byte_count,
  output logic       eop,
  output logic       rx_active,
  output logic       rx_error
);

`ifdef USB_RX_SYNC_CHECK_EN
  localparam bit SYNC_CHECK = 1'b1;
`else
  localparam bit SYNC_CHECK = 1'b0;
`endif

  localparam int            PW   = $clog2(CLKS_PER_BIT);
  localparam logic [PW-1:0] HALF = PW'(CLKS_PER_BIT / 2);
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_BIT - 1);

  logic [1:0]    line;
  logic          jk_edge;

  rx_state_t     state;
  logic [PW-1:0] phase;
  logic [PW-1:0] j_cnt;
  logic [1:0]    prev_lvl;
  logic [2:0]    ones;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          sync_done;
  logic          eop_two;

  logic          strobe, dbit;
  logic [7:0]    byte_full;
  logic          fault, keep_bit, deliver, to_eop, eop_done;

  usb_rx_edge_sync u_edge (
    .clk     (clk),
    .n_rst   (n_rst),
    .d_plus  (d_plus),
    .d_minus (d_minus),
    .line    (line),
    .jk_edge (jk_edge)
  );

  assign strobe    = (phase == HALF);
  assign dbit      = (line == prev_lvl);   // NRZI: no change means 1
  assign byte_full = {dbit, shreg[7:1]};

  // Decide what the current strobe means; the register block only applies it.
  always_comb begin
    fault    = 1'b0;
    keep_bit = 1'b0;
    deliver  = 1'b0;
    to_eop   = 1'b0;
    eop_done = 1'b0;
    if (strobe) begin
      case (state)
        RCV: begin
          if (!is_jk(line)) begin
            // SE0 is only legal on a byte boundary after SYNC
            if (bit_cnt != 3'd0 || (SYNC_CHECK && !sync_done)) fault = 1'b1;
            else                                              to_eop = 1'b1;
          end else if (ones == 3'(STUFF_LIMIT)) begin
            fault = dbit;                  // stuffed bit must be 0; 0 is dropped
          end else begin
            keep_bit = 1'b1;
            if (bit_cnt == 3'd7) begin
              if (SYNC_CHECK && !sync_done)         fault   = (byte_full != SYNC_BYTE);
              else if (byte_count == 7'(MAX_BYTES)) fault   = 1'b1;
              else                                  deliver = 1'b1;
            end
          end
        end
        EOP: begin
          if (!eop_two)              fault    = (line != LINE_SE0);
          else if (line == LINE_J)   eop_done = 1'b1;
          else                       fault    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      phase      <= '0;
      j_cnt      <= '0;
      prev_lvl   <= LINE_J;
      ones       <= 3'd0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'h00;
      sync_done  <= 1'b0;
      eop_two    <= 1'b0;
      byte_out   <= 8'h00;
      byte_ready <= 1'b0;
      byte_count <= 7'd0;
      eop        <= 1'b0;
      rx_active  <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      byte_ready <= 1'b0;
      eop        <= 1'b0;
      if (rx_clr) begin
        state      <= IDLE;
        rx_active  <= 1'b0;
        rx_error   <= 1'b0;
        byte_count <= 7'd0;
      end else if (!rx_en) begin
        state     <= IDLE;
        rx_active <= 1'b0;
      end else begin
        if (state == RCV || state == EOP)
          phase <= (jk_edge || phase == LAST) ? '0 : phase + PW'(1);

        if (fault) begin
          state     <= ERR;
          rx_active <= 1'b0;
          rx_error  <= 1'b1;
          j_cnt     <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (jk_edge && line == LINE_K) begin
                state      <= RCV;
                rx_active  <= 1'b1;
                rx_error   <= 1'b0;
                byte_count <= 7'd0;
                phase      <= '0;
                prev_lvl   <= LINE_J;
                ones       <= 3'd0;
                bit_cnt    <= 3'd0;
                sync_done  <= 1'b0;
              end
            end
            RCV: begin
              if (to_eop) begin
                state   <= EOP;
                eop_two <= 1'b0;
              end else if (strobe) begin
                prev_lvl <= line;
                if (keep_bit) begin
                  ones    <= dbit ? ones + 3'd1 : 3'd0;
                  shreg   <= byte_full;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) sync_done <= 1'b1;
                  if (deliver) begin
                    byte_out   <= byte_full;
                    byte_ready <= 1'b1;
                    byte_count <= byte_count + 7'd1;
                  end
                end else begin
                  ones <= 3'd0;
                end
              end
            end
            EOP: begin
              if (eop_done) begin
                eop       <= 1'b1;
                rx_active <= 1'b0;
                state     <= IDLE;
              end else if (strobe) begin
                eop_two <= 1'b1;
              end
            end
            ERR: begin
              // leave only after a full bit time of idle J
              if (line == LINE_J) begin
                if (j_cnt == LAST) state <= IDLE;
                else               j_cnt <= j_cnt + PW'(1);
              end else begin
                j_cnt <= '0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// tb_usb_rx_bit_timer -- self-checking bench for usb_rx_bit_timer.
// Packets are built as byte lists, bit-stuffed and NRZI-encoded into a list
// of line symbols with per-bit durations; the expected outcome (delivered
// bytes, count, eop, error) is derived from the byte list directly.
module tb_usb_rx_bit_timer;

  localparam int CPB  = 8;
  localparam int MAXB = 64;
`ifdef USB_RX_SYNC_CHECK_EN
  localparam bit SYNCCHK = 1'b1;
`else
  localparam bit SYNCCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_plus = 1'b1;
  logic       d_minus = 1'b0;
  logic       rx_en = 1'b1;
  logic       rx_clr = 1'b0;
  logic [7:0] byte_out;
  logic       byte_ready;
  logic [6:0] byte_count;
  logic       eop, rx_active, rx_error;

  usb_rx_bit_timer #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .rx_en      (rx_en),
    .rx_clr     (rx_clr),
    .byte_out   (byte_out),
    .byte_ready (byte_ready),
    .byte_count (byte_count),
    .eop        (eop),
    .rx_active  (rx_active),
    .rx_error   (rx_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int eop_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pay_q[$];
  int sym_q[$];      // 0 = J, 1 = K, 2 = SE0
  int per_q[$];
  int last_q[$];     // symbol index of each payload byte's last bit
  int lvl, ones;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: every byte_ready must match the next expected byte.
  always @(negedge clk) begin
    if (n_rst) begin
      if (byte_ready) begin
        check("byte_eop_exclusive", eop, 0);
        check("active_at_byte", rx_active, 1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h, expected none", byte_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("byte_out", byte_out, e);
        end
      end
      if (eop) begin
        eop_seen++;
        check("active_at_eop", rx_active, 0);
      end
    end
  end

  task automatic set_line(input int s);
    case (s)
      0:       {d_plus, d_minus} = 2'b10;
      1:       {d_plus, d_minus} = 2'b01;
      default: {d_plus, d_minus} = 2'b00;
    endcase
  endtask

  task automatic push_bit(input bit b, input int per);
    if (!b) lvl = (lvl == 0) ? 1 : 0;
    sym_q.push_back(lvl);
    per_q.push_back(per);
  endtask

  // stretch: first two data bytes use 9-clock bits; viol: first stuffed bit
  // is sent as 1 and the stream stops there; partial: extra bits before SE0.
  task automatic build(input bit stretch, input bit viol, input int partial);
    bit stop;
    bit b;
    int per;
    sym_q.delete();
    per_q.delete();
    last_q.delete();
    lvl  = 0;
    ones = 0;
    stop = 1'b0;
    for (int k = 0; k < pay_q.size() && !stop; k++) begin
      per = (stretch && (k == 1 || k == 2)) ? 9 : CPB;
      for (int i = 0; i < 8 && !stop; i++) begin
        b = pay_q[k][i];
        push_bit(b, per);
        if (i == 7) last_q.push_back(sym_q.size() - 1);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
          push_bit(viol, per);
          ones = 0;
          if (viol) stop = 1'b1;
        end
      end
    end
    for (int i = 0; i < partial; i++) begin
      b = 1'($urandom_range(0, 1));
      push_bit(b, CPB);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
        push_bit(1'b0, CPB);
        ones = 0;
      end
    end
    sym_q.push_back(2); per_q.push_back(CPB);
    sym_q.push_back(2); per_q.push_back(CPB);
    sym_q.push_back(0); per_q.push_back(CPB);
  endtask

  // abort_kind: 0 none, 1 n_rst pulse in byte 2, 2 rx_en drop in byte 2
  task automatic run_packet(input bit stretch, input bit viol, input int partial,
                            input int abort_kind);
    int a, done, first, deliv, exp_eop, exp_cnt, exp_err;
    build(stretch, viol, partial);
    a = (abort_kind != 0) ? last_q[1] + 4 : sym_q.size();
    done = 0;
    foreach (last_q[k]) if (last_q[k] < a) done++;
    first = SYNCCHK ? 1 : 0;
    deliv = done - first;
    if (deliv < 0) deliv = 0;
    exp_err = ((viol || partial != 0) && abort_kind == 0) ? 1 : 0;
    if (deliv > MAXB) begin
      exp_err = 1;
      deliv   = MAXB;
    end
    for (int k = 0; k < deliv; k++) exp_q.push_back(pay_q[first + k]);
    exp_eop = (exp_err == 0 && abort_kind == 0) ? 1 : 0;
    exp_cnt = (abort_kind == 1) ? 0 : deliv;
    eop_seen = 0;

    for (int i = 0; i < sym_q.size() && i < a; i++) begin
      set_line(sym_q[i]);
      repeat (per_q[i]) @(negedge clk);
    end
    set_line(0);
    if (abort_kind == 1) begin
      n_rst = 1'b0;
      #1;
      check("rst_byte_out", byte_out, 0);
      check("rst_byte_ready", byte_ready, 0);
      check("rst_byte_count", byte_count, 0);
      check("rst_eop", eop, 0);
      check("rst_rx_active", rx_active, 0);
      check("rst_rx_error", rx_error, 0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
    end else if (abort_kind == 2) begin
      rx_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rx_en_drop_active", rx_active, 0);
    end
    repeat (40) @(negedge clk);
    rx_en = 1'b1;

    check("leftover_bytes", exp_q.size(), 0);
    exp_q.delete();
    check("eop_count", eop_seen, exp_eop);
    check("rx_error", rx_error, exp_err);
    check("byte_count", byte_count, exp_cnt);
    check("rx_active_idle", rx_active, 0);
  endtask

  task automatic load_random(input int n);
    pay_q.delete();
    pay_q.push_back(8'h80);
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_byte_out", byte_out, 0);
    check("reset_byte_ready", byte_ready, 0);
    check("reset_byte_count", byte_count, 0);
    check("reset_eop", eop, 0);
    check("reset_rx_active", rx_active, 0);
    check("reset_rx_error", rx_error, 0);
    n_rst = 1'b1;
    repeat (10) @(negedge clk);

    // two data bytes, clean EOP
    pay_q = '{8'h80, 8'hA5, 8'h3C};
    run_packet(1'b0, 1'b0, 0, 0);
    check("lit_last_byte", byte_out, 8'h3C);
    check("lit_count_2", byte_count, SYNCCHK ? 2 : 3);

    // 0xFF needs a stuffed 0 which must not be counted
    pay_q = '{8'h80, 8'hFF};
    run_packet(1'b0, 1'b0, 0, 0);
    check("lit_ff_byte", byte_out, 8'hFF);
    check("lit_ff_count", byte_count, SYNCCHK ? 1 : 2);

    // same stream with the stuffed bit sent as 1
    pay_q = '{8'h80, 8'hFF};
    run_packet(1'b0, 1'b1, 0, 0);
    check("lit_stuff_err", rx_error, 1);

    // 9-clock bits across two data bytes
    pay_q = '{8'h80, 8'h55, 8'hAA, 8'h3C};
    run_packet(1'b1, 1'b0, 0, 0);
    check("lit_drift_last", byte_out, 8'h3C);

    // one byte over the limit
    load_random(MAXB + (SYNCCHK ? 1 : 0));
    run_packet(1'b0, 1'b0, 0, 0);
    check("lit_max_count", byte_count, MAXB);
    check("lit_max_err", rx_error, 1);

    // SE0 after 3 bits of a byte, then rx_clr
    load_random(1);
    run_packet(1'b0, 1'b0, 3, 0);
    check("lit_partial_err", rx_error, 1);
    rx_clr = 1'b1;
    @(negedge clk);
    rx_clr = 1'b0;
    @(negedge clk);
    check("clr_rx_error", rx_error, 0);
    check("clr_byte_count", byte_count, 0);
    check("clr_rx_active", rx_active, 0);

    // reset during byte 2, then a clean packet
    load_random(3);
    run_packet(1'b0, 1'b0, 0, 1);
    load_random(2);
    run_packet(1'b0, 1'b0, 0, 0);

    // rx_en dropped during byte 2
    load_random(3);
    run_packet(1'b0, 1'b0, 0, 2);

    for (int n = 0; n < 6; n++) begin
      load_random($urandom_range(1, 6));
      run_packet(1'b0, 1'b0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
